// File: rtl/ftf_decoder_16_if.sv
// ftf_decoder_16_if
//   Bus bundle for the FTF decoder: codeword input handshake plus decoded-word
//   output handshake.
//   code_in/in_valid/in_ready     : upstream codeword handshake
//   data_out/err_out/out_valid/out_ready : downstream decoded-word handshake
//   modport slave  : decoder side
//   modport master : link/consumer side
`ifndef FBLEN16
`define FBLEN16 12
`endif

interface ftf_decoder_16_if #(
  parameter int CW = 16,
  parameter int DW = `FBLEN16
);
  logic [CW-1:0] code_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          err_out;
  logic          out_valid;
  logic          out_ready;

  modport slave (
    input  code_in, in_valid, out_ready,
    output in_ready, data_out, err_out, out_valid
  );

  modport master (
    output code_in, in_valid, out_ready,
    input  in_ready, data_out, err_out, out_valid
  );
endinterface

// File: rtl/ftf_decoder_16.sv
// ftf_decoder_16
//   Receiver stage for 16-wire FTF codewords. Rebuilds the binary word as a
//   Fibonacci-weighted sum in two pipeline stages (low/high byte partial sums,
//   then final add), with valid/ready on both sides and an overflow flag that
//   travels with each word plus a saturating overflow counter.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high, highest priority
//   bus       : ftf_decoder_16_if.slave (code_in/in_valid/in_ready in,
//               data_out/err_out/out_valid/out_ready out)
//   err_count : number of delivered words flagged as overflowed, saturating
`ifndef FBLEN16
`define FBLEN16 12
`endif
`ifndef FNS01
`define FNS01 1
`define FNS02 2
`define FNS03 3
`define FNS04 5
`define FNS05 8
`define FNS06 13
`define FNS07 21
`define FNS08 34
`define FNS09 55
`define FNS10 89
`define FNS11 144
`define FNS12 233
`define FNS13 377
`define FNS14 610
`define FNS15 987
`define FNS16 1597
`define FNS17 2584
`endif

module ftf_decoder_16 #(
  parameter int CW   = 16,
  parameter int DW   = `FBLEN16,
  parameter int ERRW = 16
) (
  input  logic            clock,
  input  logic            reset,
  ftf_decoder_16_if.slave bus,
  output logic [ERRW-1:0] err_count
);

  // Weight of codeword bit idx; bit 0 weighs 1, bit i weighs FNS(i+1).
  function automatic logic [DW:0] weight(input logic [3:0] idx);
    logic [DW:0] w;
    case (idx)
      4'd0:    w = (DW+1)'(`FNS01);
      4'd1:    w = (DW+1)'(`FNS02);
      4'd2:    w = (DW+1)'(`FNS03);
      4'd3:    w = (DW+1)'(`FNS04);
      4'd4:    w = (DW+1)'(`FNS05);
      4'd5:    w = (DW+1)'(`FNS06);
      4'd6:    w = (DW+1)'(`FNS07);
      4'd7:    w = (DW+1)'(`FNS08);
      4'd8:    w = (DW+1)'(`FNS09);
      4'd9:    w = (DW+1)'(`FNS10);
      4'd10:   w = (DW+1)'(`FNS11);
      4'd11:   w = (DW+1)'(`FNS12);
      4'd12:   w = (DW+1)'(`FNS13);
      4'd13:   w = (DW+1)'(`FNS14);
      4'd14:   w = (DW+1)'(`FNS15);
      4'd15:   w = (DW+1)'(`FNS16);
      default: w = '0;
    endcase
    return w;
  endfunction

  // Weighted sum of one byte of the codeword; base selects which byte.
  function automatic logic [DW:0] byte_sum(input logic [7:0] bits, input logic [3:0] base);
    logic [DW:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (bits[i]) begin
        acc = acc + weight(base + 4'(i));
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  logic            s1_v_q, s1_v_d;
  logic [DW:0]     s1_lo_q, s1_lo_d;
  logic [DW:0]     s1_hi_q, s1_hi_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  logic [CW-1:0]   code_s;
  logic            s2_free;
  logic            in_ready_s;
  logic            in_xfer;
  logic            s1_adv;
  logic            out_xfer;
  logic [DW:0]     sum_s;

  // Handshake decode and next-state for both pipeline stages and the counter.
  always_comb begin
    code_s      = bus.code_in;
    s2_free     = !out_valid_q || bus.out_ready;
    in_ready_s  = !s1_v_q || s2_free;
    in_xfer     = bus.in_valid && in_ready_s;
    s1_adv      = s1_v_q && s2_free;
    out_xfer    = out_valid_q && bus.out_ready;
    // Carry out of the final add lands in bit DW and becomes the overflow flag.
    sum_s       = s1_lo_q + s1_hi_q;

    s1_v_d      = s1_v_q;
    s1_lo_d     = s1_lo_q;
    s1_hi_d     = s1_hi_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    // S1 loads on input transfer; it empties only if it advanced without a refill.
    if (in_xfer) begin
      s1_v_d  = 1'b1;
      s1_lo_d = byte_sum(code_s[7:0], 4'd0);
      s1_hi_d = byte_sum(code_s[15:8], 4'd8);
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end

    // Output register refills from S1 or drains; otherwise it holds through a stall.
    if (s1_adv) begin
      out_valid_d = 1'b1;
      data_d      = sum_s[DW-1:0];
      err_d       = sum_s[DW];
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Count delivered overflowed words, sticking at all-ones.
    if (out_xfer && err_q && (err_count_q != {ERRW{1'b1}})) begin
      err_count_d = err_count_q + ERRW'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Pipeline and counter registers; reset discards anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_lo_q     <= '0;
      s1_hi_q     <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_lo_q     <= s1_lo_d;
      s1_hi_q     <= s1_hi_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.data_out  = data_q;
  assign bus.err_out   = err_q;
  assign bus.out_valid = out_valid_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_ftf_decoder_16.sv
// Directed bench for ftf_decoder_16 with a scoreboard queue: expected words are
// pushed when an input transfer is seen and popped when an output transfer is seen.
// A second instance with a 2-bit error counter shares the same stimulus.
module tb_ftf_decoder_16;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ftf_decoder_16_if #(.CW(16), .DW(DW)) bus ();
  ftf_decoder_16_if #(.CW(16), .DW(DW)) bus2 ();
  logic [15:0] err_count;
  logic [1:0]  err_count2;

  assign bus2.code_in   = bus.code_in;
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.out_ready = bus.out_ready;

  ftf_decoder_16 #(.CW(16), .DW(DW), .ERRW(16)) dut (
    .clock(clk), .reset(rst), .bus(bus), .err_count(err_count));
  ftf_decoder_16 #(.CW(16), .DW(DW), .ERRW(2)) dut_sat (
    .clock(clk), .reset(rst), .bus(bus2), .err_count(err_count2));

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_n   = 0;
  int          n_out   = 0;
  logic [15:0] exp_ec  = 16'd0;
  logic [1:0]  exp_ec2 = 2'd0;
  bit          chk_lat = 1'b0;
  int          w[16];

  function automatic logic [DW:0] model_sum(input logic [15:0] c);
    logic [DW:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) if (c[i]) s = s + (DW+1)'(w[i]);
    return s;
  endfunction

  // Greedy Fibonacci encoder standing in for the registered FTF encoder.
  function automatic logic [15:0] encode(input int d);
    logic [15:0] c;
    int r;
    c = 16'h0000;
    r = d;
    for (int i = 15; i >= 0; i--) begin
      if (r >= w[i]) begin
        c[i] = 1'b1;
        r = r - w[i];
      end
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at the falling edge, score the transfers about to happen, step.
  task automatic cyc(input logic v, input logic [15:0] c, input logic ordy,
                     input logic [DW:0] expv, output logic acc);
    exp_t e;
    bus.in_valid  = v;
    bus.code_in   = c;
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    if (!rst) begin
      check("err_count", err_count, exp_ec);
      check("err_count_sat", err_count2, exp_ec2);
      if (bus.out_valid && ordy) begin
        n_out++;
        check("output_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data_out", bus.data_out, e.data);
          check("err_out", bus.err_out, e.err);
          if (chk_lat) check("latency", cyc_n - e.cyc, 2);
          if (e.err) begin
            if (exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
            if (exp_ec2 != 2'd3) exp_ec2 = exp_ec2 + 2'd1;
          end
        end
      end
      if (v && bus.in_ready) begin
        acc = 1'b1;
        e.data = expv[DW-1:0];
        e.err  = expv[DW];
        e.cyc  = cyc_n;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    if (rst) begin
      sb.delete();
      exp_ec  = 16'd0;
      exp_ec2 = 2'd0;
    end
    @(negedge clk);
    cyc_n++;
  endtask

  logic        acc;
  logic [15:0] codes[8];
  int          dvals[8];
  int          idx;
  int          out0;
  bit          saw_block;
  logic [15:0] cw;
  logic [1:0]  satseq[5];

  initial begin
    w[0] = 1;
    w[1] = 2;
    for (int i = 2; i < 16; i++) w[i] = w[i-1] + w[i-2];
    satseq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.code_in = 16'h0000; bus.out_ready = 1'b1;
    @(negedge clk);
    cyc(1'b1, 16'hFFFF, 1'b1, 13'd0, acc);
    cyc(1'b1, 16'hFFFF, 1'b1, 13'd0, acc);
    rst = 1'b0;

    // Reset state
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_data_out", bus.data_out, 12'd0);
    check("rst_err_out", bus.err_out, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // Single-bit weights, full throughput
    chk_lat = 1'b1;
    cyc(1'b1, 16'h0001, 1'b1, 13'd1, acc);
    cyc(1'b1, 16'h0002, 1'b1, 13'd2, acc);
    cyc(1'b1, 16'h8000, 1'b1, 13'd1597, acc);
    cyc(1'b1, 16'h0100, 1'b1, 13'd55, acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);

    // Round trip through the encoder
    dvals[0] = 0;
    dvals[1] = 1;
    dvals[2] = 2583;
    for (int i = 3; i < 8; i++) dvals[i] = int'($urandom_range(2583, 0));
    for (int i = 0; i < 8; i++) cyc(1'b1, encode(dvals[i]), 1'b1, (DW+1)'(dvals[i]), acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);
    check("roundtrip_drained", sb.size(), 0);

    // Back-to-back stream with a 3-cycle output stall
    chk_lat = 1'b0;
    for (int i = 0; i < 8; i++) codes[i] = encode(int'($urandom_range(2583, 0)));
    idx = 0;
    saw_block = 1'b0;
    out0 = n_out;
    for (int c = 0; c < 20; c++) begin
      cw = (idx < 8) ? codes[idx] : 16'h0000;
      cyc(idx < 8, cw, !(c >= 3 && c <= 5), model_sum(cw), acc);
      if (idx < 8 && !acc) saw_block = 1'b1;
      if (acc) idx++;
    end
    check("stall_in_ready_fell", saw_block, 1'b1);
    check("stall_all_accepted", idx, 8);
    check("stall_outputs", n_out - out0, 8);
    check("stall_drained", sb.size(), 0);

    // Overflow word held under backpressure
    cyc(1'b1, 16'hFFFF, 1'b0, 13'd4179, acc);
    cyc(1'b0, 16'h0000, 1'b0, 13'd0, acc);
    cyc(1'b0, 16'h0000, 1'b0, 13'd0, acc);
    check("ovf_out_valid", bus.out_valid, 1'b1);
    check("ovf_data_out", bus.data_out, 12'd83);
    check("ovf_err_out", bus.err_out, 1'b1);
    check("ovf_count_stalled", err_count, 16'd0);
    cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);
    cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);
    check("ovf_count_after", err_count, 16'd1);

    // Saturation of the 2-bit counter
    rst = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, 16'hFFFF, 1'b1, 13'd4179, acc);
      cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);
      cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);
      check("sat_count16", err_count, 16'(k));
      check("sat_count2", err_count2, satseq[k-1]);
    end

    // Reset with both stages full
    cyc(1'b1, 16'hFFFF, 1'b0, 13'd4179, acc);
    cyc(1'b1, 16'hFFFF, 1'b0, 13'd4179, acc);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    #1;
    check("full_out_valid", bus.out_valid, 1'b1);
    check("full_in_ready", bus.in_ready, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 16'h0001, 1'b1, 13'd0, acc);
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    check("rst2_out_valid", bus.out_valid, 1'b0);
    check("rst2_err_count", err_count, 16'd0);
    check("rst2_err_count_sat", err_count2, 2'd0);
    check("rst2_in_ready", bus.in_ready, 1'b1);
    chk_lat = 1'b1;
    out0 = n_out;
    cyc(1'b1, encode(100), 1'b1, 13'd100, acc);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 13'd0, acc);
    check("rst2_outputs", n_out - out0, 1);
    check("rst2_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
